// File: rtl/dff_response_checker_if.sv
// Monitor-side bundle for a D flip-flop under test: D/Q/QB taps, control, check status.
// FF_CHK_CAPTURE_EN adds the first-error capture fields.
interface dff_response_checker_if #(
    parameter int CNT_W = 16
);
    logic             EN;
    logic             CLR;
    logic             D_MON;
    logic             Q_MON;
    logic             QB_MON;
    logic             ERR_PULSE;
    logic             ERR_STICKY;
    logic [CNT_W-1:0] CHK_CNT;
    logic [CNT_W-1:0] ERR_CNT;
    logic [1:0]       STATE;
`ifdef FF_CHK_CAPTURE_EN
    logic [CNT_W-1:0] FIRST_ERR_IDX;
    logic             FIRST_ERR_EXP;
    logic             FIRST_ERR_Q;
    logic             FIRST_ERR_CTYP;
`endif

    modport master (
        output EN, CLR, D_MON, Q_MON, QB_MON,
`ifdef FF_CHK_CAPTURE_EN
        input  FIRST_ERR_IDX, FIRST_ERR_EXP, FIRST_ERR_Q, FIRST_ERR_CTYP,
`endif
        input  ERR_PULSE, ERR_STICKY, CHK_CNT, ERR_CNT, STATE
    );

    modport slave (
        input  EN, CLR, D_MON, Q_MON, QB_MON,
`ifdef FF_CHK_CAPTURE_EN
        output FIRST_ERR_IDX, FIRST_ERR_EXP, FIRST_ERR_Q, FIRST_ERR_CTYP,
`endif
        output ERR_PULSE, ERR_STICKY, CHK_CNT, ERR_CNT, STATE
    );
endinterface

// File: rtl/dff_response_checker.sv
// One-cycle reference checker for a D flip-flop: flags Q mismatches and Q/QB complement errors.
// Optional macro FF_CHK_CAPTURE_EN records details of the first error.
module dff_response_checker #(
    parameter int CNT_W       = 16,
    parameter int ARM_CYCLES  = 2,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                  C,
    input  logic                  RSTN,
    dff_response_checker_if.slave mon
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_CHECK = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    localparam logic [3:0]       ARM_LAST = 4'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [3:0]       arm_q, arm_d;
    logic             exp_q, exp_d;
    logic             pulse_q, pulse_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] chk_q, chk_d;
    logic [CNT_W-1:0] errc_q, errc_d;
`ifdef FF_CHK_CAPTURE_EN
    logic [CNT_W-1:0] cap_idx_q, cap_idx_d;
    logic             cap_exp_q, cap_exp_d;
    logic             cap_qv_q, cap_qv_d;
    logic             cap_ctyp_q, cap_ctyp_d;
`endif

    logic qerr, cerr, err;
    assign qerr = (mon.Q_MON != exp_q);
    assign cerr = (mon.QB_MON != ~mon.Q_MON);
    assign err  = qerr | cerr;

    always_comb begin
        state_d  = state_q;
        arm_d    = arm_q;
        exp_d    = mon.D_MON;  // reference tracks D in every state, including CLR
        pulse_d  = 1'b0;
        sticky_d = sticky_q;
        chk_d    = chk_q;
        errc_d   = errc_q;
`ifdef FF_CHK_CAPTURE_EN
        cap_idx_d  = cap_idx_q;
        cap_exp_d  = cap_exp_q;
        cap_qv_d   = cap_qv_q;
        cap_ctyp_d = cap_ctyp_q;
`endif
        if (mon.CLR) begin
            state_d  = S_IDLE;
            arm_d    = 4'd0;
            sticky_d = 1'b0;
            chk_d    = '0;
            errc_d   = '0;
`ifdef FF_CHK_CAPTURE_EN
            cap_idx_d  = '0;
            cap_exp_d  = 1'b0;
            cap_qv_d   = 1'b0;
            cap_ctyp_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mon.EN) begin
                        state_d = S_ARMED;
                        arm_d   = 4'd0;
                    end
                end
                S_ARMED: begin
                    if (!mon.EN) begin
                        state_d = S_IDLE;
                    end else begin
                        arm_d = arm_q + 4'd1;
                        if (arm_q == ARM_LAST) state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!mon.EN) begin
                        state_d = S_IDLE;
                    end else begin
                        chk_d = (chk_q == CNT_MAX) ? chk_q : chk_q + CNT_ONE;
                        if (err) begin
                            pulse_d  = 1'b1;
                            sticky_d = 1'b1;
                            errc_d   = (errc_q == CNT_MAX) ? errc_q : errc_q + CNT_ONE;
                            if (STOP_ON_ERR) state_d = S_FAIL;
`ifdef FF_CHK_CAPTURE_EN
                            // index is the compare count before this edge is added
                            if (!sticky_q) begin
                                cap_idx_d  = chk_q;
                                cap_exp_d  = exp_q;
                                cap_qv_d   = mon.Q_MON;
                                cap_ctyp_d = cerr;
                            end
`endif
                        end
                    end
                end
                default: state_d = S_FAIL;
            endcase
        end
    end

    always_ff @(posedge C or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            arm_q    <= 4'd0;
            exp_q    <= 1'b0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            chk_q    <= '0;
            errc_q   <= '0;
`ifdef FF_CHK_CAPTURE_EN
            cap_idx_q  <= '0;
            cap_exp_q  <= 1'b0;
            cap_qv_q   <= 1'b0;
            cap_ctyp_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            arm_q    <= arm_d;
            exp_q    <= exp_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            chk_q    <= chk_d;
            errc_q   <= errc_d;
`ifdef FF_CHK_CAPTURE_EN
            cap_idx_q  <= cap_idx_d;
            cap_exp_q  <= cap_exp_d;
            cap_qv_q   <= cap_qv_d;
            cap_ctyp_q <= cap_ctyp_d;
`endif
        end
    end

    assign mon.STATE      = state_q;
    assign mon.ERR_PULSE  = pulse_q;
    assign mon.ERR_STICKY = sticky_q;
    assign mon.CHK_CNT    = chk_q;
    assign mon.ERR_CNT    = errc_q;
`ifdef FF_CHK_CAPTURE_EN
    assign mon.FIRST_ERR_IDX  = cap_idx_q;
    assign mon.FIRST_ERR_EXP  = cap_exp_q;
    assign mon.FIRST_ERR_Q    = cap_qv_q;
    assign mon.FIRST_ERR_CTYP = cap_ctyp_q;
`endif
endmodule

// File: doc/dff_response_checker.md
Name: dff_response_checker

Overview:
- Synthesizable companion monitor for the D flip-flop under test; it sits on the receiving end of the D/Q/QB interface.
- It watches the data driven into the flip-flop and the Q/QB it returns.
- It keeps a one-cycle reference model, flags mismatches and complement violations, and counts checked and failed cycles.
- It is instantiated in benches and on-board test wrappers next to the flip-flop instance.

Parameters:
- CNT_W, 16, width of the check and error counters.
- ARM_CYCLES, 2, clock edges spent in ARMED before comparisons start (range 1..15).
- STOP_ON_ERR, 0, 1 = freeze in FAIL on the first error; 0 = keep checking.

Ports:
- C  input  1  clock; all sampling on the rising edge.
- RSTN  input  1  asynchronous active-low reset.
- EN  input  1  checking enable; level sensitive.
- CLR  input  1  synchronous clear of counters and sticky flags; returns FSM to IDLE.
- D_MON  input  1  D as driven into the flip-flop.
- Q_MON  input  1  Q from the flip-flop.
- QB_MON  input  1  QB from the flip-flop.
- ERR_PULSE  output  1  one-cycle pulse on any detected error.
- ERR_STICKY  output  1  set on the first error; held until CLR or reset.
- CHK_CNT  output  CNT_W  number of compared cycles (saturating).
- ERR_CNT  output  CNT_W  number of failed cycles (saturating).
- STATE  output  2  FSM state: 0 IDLE, 1 ARMED, 2 CHECK, 3 FAIL.

Behaviour:
- Reset (RSTN=0, asynchronous): every register is cleared regardless of C.
  - Outputs: ERR_PULSE=0, ERR_STICKY=0, CHK_CNT=0, ERR_CNT=0, STATE=IDLE.
  - Internal: exp_q=0, arm counter=0.
- Reset release is synchronous to the next rising edge of C.
- Reference model: exp_q <= D_MON on every rising edge in any state, so exp_q always holds the D of the previous edge.
- Comparison at rising edge k (CHECK state only): qerr = (Q_MON != exp_q); cerr = (QB_MON != ~Q_MON); err = qerr | cerr.
- Latency: an error at edge k appears on ERR_PULSE, ERR_STICKY and ERR_CNT after edge k (registered, one cycle).
- FSM transitions:
  - IDLE -> ARMED when EN=1; the arm counter loads 0.
  - ARMED: the arm counter increments each edge. Move to CHECK when the counter reaches ARM_CYCLES-1 and EN=1. Return to IDLE if EN=0. No comparisons and no counting in ARMED.
  - CHECK -> IDLE when EN=0; that edge is not compared.
  - CHECK -> FAIL when err=1 and STOP_ON_ERR=1.
  - CHECK stays in CHECK when err=1 and STOP_ON_ERR=0.
  - FAIL is held until CLR=1. EN is ignored. Counters and ERR_PULSE are frozen, ERR_PULSE=0.
- Counters:
  - CHK_CNT increments on every compared edge.
  - ERR_CNT increments when err=1.
  - Both saturate at 2^CNT_W-1, with no wrap.
- Simultaneous events:
  - CLR has priority over EN and err: the counters, ERR_STICKY and ERR_PULSE clear, and STATE goes to IDLE on that edge. The error is not counted.
  - A CLR that coincides with EN=1 gives IDLE on that edge; the next edge goes to ARMED.
- exp_q keeps updating during CLR and IDLE, so re-arming after CLR needs no extra flush beyond ARMED.

Optional Feature:
- Macro: FF_CHK_CAPTURE_EN.
- When defined, extra outputs are added:
  - FIRST_ERR_IDX [CNT_W]: the CHK_CNT value at the first error.
  - FIRST_ERR_EXP [1]: exp_q at that edge.
  - FIRST_ERR_Q [1]: Q_MON at that edge.
  - FIRST_ERR_CTYP [1]: 1 if the error was a complement violation.
  - These are captured once, when ERR_STICKY goes 0->1. They are cleared by reset or CLR.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset mid-check: run 10 good CHECK cycles, assert RSTN=0 between clock edges -> all outputs are 0 and STATE=0 immediately, not waiting for the next edge.
- Good flip-flop, ARM_CYCLES=2: EN=1, D sequence 1,0,1,1,0 with correct Q/QB -> STATE goes 0,1,1,2. CHK_CNT counts once per CHECK edge. ERR_CNT=0 and ERR_STICKY=0 throughout.
- Stuck-at-0 Q, STOP_ON_ERR=0: D=1 held for 4 checked edges, Q=0, QB=1 -> ERR_PULSE high for 4 cycles, ERR_CNT=4, ERR_STICKY=1, STATE stays 2.
- Complement violation, STOP_ON_ERR=1: at the 3rd checked edge Q=1 and QB=1 -> STATE=3 from the next edge. ERR_CNT=1 and stays frozen while EN remains 1. With FF_CHK_CAPTURE_EN: FIRST_ERR_IDX=2, FIRST_ERR_CTYP=1.
- Counter saturation, CNT_W=4: inject 20 consecutive errors -> ERR_CNT=15 and CHK_CNT=15, no wrap.
- CLR collides with error: CLR=1 on the same edge as a Q mismatch -> ERR_CNT=0, ERR_STICKY=0, STATE=0. With EN held at 1, STATE=1 on the following edge.
